framebuffer_scanout: RTL and testbench
======================================

// Module: framebuffer_scanout
// PURPOSE
//  Downstream consumer of the framebuffer filled by the triangle rasteriser.
//  Reads RGB565 pixels from the framebuffer read port in raster order and emits
//  a timed pixel stream: RGB, pixel_valid, active-low hsync/vsync, frame/blank
//  flags. Sits between the framebuffer RAM (sync read, 1-cycle latency) and the
//  display PHY.
// PARAMETERS
//  DISPLAY_WIDTH          100   active pixels per line
//  DISPLAY_HEIGHT         100   active lines per frame
//  FRAMEBUFFER_DATA_BITS  16    pixel width, {r[4:0],g[5:0],b[4:0]}
//  FRAMEBUFFER_SIZE       W*H   framebuffer depth (words)
//  FRAMEBUFFER_ADDR_BITS  $clog2(FRAMEBUFFER_SIZE)  read address width
//  H_FRONT/H_SYNC/H_BACK  4/8/4 horizontal porch/sync widths (clocks, each >=1)
//  V_FRONT/V_SYNC/V_BACK  2/2/2 vertical porch/sync heights (lines, each >=1)
// PORTS
//  clk                  in   1   pixel clock, all logic on posedge
//  rst                  in   1   synchronous, active-high reset
//  enable               in   1   start/continue scanout
//  framebuffer_rd_addr  out  FRAMEBUFFER_ADDR_BITS  read address to framebuffer
//  framebuffer_rd_data  in   FRAMEBUFFER_DATA_BITS  data for addr of previous clk
//  pixel_valid          out  1   pixel_r/g/b carry an active pixel this cycle
//  pixel_r/g/b          out  5/6/5  pixel colour; 0 whenever pixel_valid=0
//  hsync_n, vsync_n     out  1   active-low syncs
//  vblank               out  1   high outside active lines (or in IDLE)
//  frame_start          out  1   1-clk pulse aligned with first pixel of frame
// BEHAVIOUR
//  - H_TOTAL=W+H_FRONT+H_SYNC+H_BACK; V_TOTAL=H+V_FRONT+V_SYNC+V_BACK.
//  - FSM: IDLE -> RUN when enable=1 (counters h=v=0 on entry). In RUN, h counts
//    0..H_TOTAL-1, wraps to 0 and increments v; v wraps at V_TOTAL-1.
//    enable=0 in RUN: finish current frame; at wrap (h=H_TOTAL-1,v=V_TOTAL-1)
//    go IDLE. enable=1 at that wrap: stay RUN, next frame begins without gap.
//  - Stage 0 (counters): active = h<W && v<H. framebuffer_rd_addr is a running
//    counter (no multiplier): +1 per active clk, 0 at frame wrap/IDLE; never
//    exceeds W*H-1. Address driven combinationally from the counter.
//  - Stage 1 (registered): every output is stage-0 state delayed exactly 1 clk,
//    so rd_data lines up with its own pixel_valid/syncs. Latency enable->first
//    pixel_valid: IDLE->RUN transition clk + 1.
//  - hsync_n=0 when W+H_FRONT <= h < W+H_FRONT+H_SYNC; vsync_n=0 for all h of
//    lines H+V_FRONT <= v < H+V_FRONT+V_SYNC. frame_start=1 for h=0,v=0 of RUN.
//  - Reset (or IDLE outputs): rd_addr=0, pixel_valid=0, rgb=0, hsync_n=1,
//    vsync_n=1, vblank=1, frame_start=0, FSM=IDLE. rst mid-frame aborts
//    immediately; next frame restarts at h=v=0, addr 0.
//  - Framebuffer writes during scanout are not arbitrated here (tearing allowed);
//    vblank is exposed so the writer may defer.
// CONFIGURATION
//  SCANOUT_TEST_PATTERN_EN defined: rd_data ignored; active pixels show 8
//   vertical colour bars, bar = (h*8)/W, colour {r,g,b} = {bar[2]?1F:0,
//   bar[1]?3F:0, bar[0]?1F:0}; rd_addr held at 0. Timing identical.
//  Undefined: pixels sourced from framebuffer_rd_data as above.
// TESTING (W=4,H=3, H 1/2/1 -> H_TOTAL=8, V 1/1/1 -> V_TOTAL=6, 48 clk/frame)
//  1. rst=1 3 clk, enable=0 -> all outputs at reset values, no rd_addr motion.
//  2. enable=1, RAM returns data=addr+0x100 -> pixel_valid 4 clk/line x 3 lines,
//     pixels 0x100..0x10B in order, 1 clk after each rd_addr; frame_start once.
//  3. Sync check: hsync_n low output clks 6-7 of every line (after 1-clk delay);
//     vsync_n low for all 8 clks of line 4; vblank high on lines 3-5.
//  4. enable dropped at line 1 -> frame completes (12 pixels), FSM IDLE after
//     clk 48; enable held -> frame 2 starts back-to-back, rd_addr restarts at 0.
//  5. rst asserted at line 1, h=2 -> next clk outputs at reset values; after
//     release+enable, first pixel is addr 0.
//  6. SCANOUT_TEST_PATTERN_EN with W=8 -> line pixels 0x0000,0x001F,0x07E0,
//     0x07FF,0xF800,0xF81F,0xFFE0,0xFFFF; rd_addr constant 0.

Source files
------------

// File: rtl/framebuffer_scanout.sv
// Raster-order framebuffer scanout with a one-cycle registered output stage.
// Define SCANOUT_TEST_PATTERN_EN to replace framebuffer data with eight colour bars.
module framebuffer_scanout #(
    parameter int DISPLAY_WIDTH         = 100,
    parameter int DISPLAY_HEIGHT        = 100,
    parameter int FRAMEBUFFER_DATA_BITS = 16,
    parameter int FRAMEBUFFER_SIZE      = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    parameter int FRAMEBUFFER_ADDR_BITS = $clog2(FRAMEBUFFER_SIZE),
    parameter int H_FRONT               = 4,
    parameter int H_SYNC                = 8,
    parameter int H_BACK                = 4,
    parameter int V_FRONT               = 2,
    parameter int V_SYNC                = 2,
    parameter int V_BACK                = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    output logic [FRAMEBUFFER_ADDR_BITS-1:0] framebuffer_rd_addr,
    input  logic [FRAMEBUFFER_DATA_BITS-1:0] framebuffer_rd_data,
    output logic                             pixel_valid,
    output logic [4:0]                       pixel_r,
    output logic [5:0]                       pixel_g,
    output logic [4:0]                       pixel_b,
    output logic                             hsync_n,
    output logic                             vsync_n,
    output logic                             vblank,
    output logic                             frame_start
);

    localparam int H_TOTAL = DISPLAY_WIDTH + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = DISPLAY_HEIGHT + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = FRAMEBUFFER_ADDR_BITS;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(DISPLAY_WIDTH);
    localparam logic [HW-1:0] HS_START = HW'(DISPLAY_WIDTH + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(DISPLAY_WIDTH + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(DISPLAY_HEIGHT);
    localparam logic [VW-1:0] VS_START = VW'(DISPLAY_HEIGHT + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(DISPLAY_HEIGHT + V_FRONT + V_SYNC);
    localparam logic [AW-1:0] ADDR_LAST = AW'(FRAMEBUFFER_SIZE - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_next;
    logic [HW-1:0] h, h_next;
    logic [VW-1:0] v, v_next;
    logic [AW-1:0] addr, addr_next;
    logic          run, active, h_wrap, frame_wrap;

    assign run        = (state == RUN);
    assign active     = run && (h < H_ACT) && (v < V_ACT);
    assign h_wrap     = (h == H_LAST);
    assign frame_wrap = h_wrap && (v == V_LAST);

    assign framebuffer_rd_addr = addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            h     <= '0;
            v     <= '0;
            addr  <= '0;
        end else begin
            state <= state_next;
            h     <= h_next;
            v     <= v_next;
            addr  <= addr_next;
        end
    end

    // The enable decision is only taken at the frame wrap so frames never truncate.
    always_comb begin
        state_next = state;
        h_next     = h;
        v_next     = v;
        addr_next  = addr;
        case (state)
            IDLE: begin
                h_next    = '0;
                v_next    = '0;
                addr_next = '0;
                if (enable) state_next = RUN;
            end
            RUN: begin
                if (h_wrap) begin
                    h_next = '0;
                    v_next = (v == V_LAST) ? '0 : v + 1'b1;
                end else begin
                    h_next = h + 1'b1;
                end
                if (frame_wrap) begin
                    addr_next = '0;
                    if (!enable) state_next = IDLE;
                end else if (active) begin
`ifdef SCANOUT_TEST_PATTERN_EN
                    addr_next = '0;
`else
                    addr_next = (addr == ADDR_LAST) ? '0 : addr + 1'b1;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_valid <= 1'b0;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            vblank      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            pixel_valid <= active;
            hsync_n     <= !(run && (h >= HS_START) && (h < HS_END));
            vsync_n     <= !(run && (v >= VS_START) && (v < VS_END));
            vblank      <= !run || (v >= V_ACT);
            frame_start <= run && (h == '0) && (v == '0);
        end
    end

`ifdef SCANOUT_TEST_PATTERN_EN
    localparam logic [HW+2:0] W_WIDE = (HW + 3)'(DISPLAY_WIDTH);

    logic [HW+2:0] h_x8;
    logic [2:0]    bar;
    logic [15:0]   pattern_q;
    logic          unused_rd_data;

    assign unused_rd_data = ^framebuffer_rd_data;
    assign h_x8           = {h, 3'b000};
    assign bar            = 3'(h_x8 / W_WIDE);

    // Bar colour is registered alongside the other stage-1 outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= '0;
        end else if (active) begin
            pattern_q <= {bar[2] ? 5'h1F : 5'h00, bar[1] ? 6'h3F : 6'h00, bar[0] ? 5'h1F : 5'h00};
        end else begin
            pattern_q <= '0;
        end
    end

    assign pixel_r = pattern_q[15:11];
    assign pixel_g = pattern_q[10:5];
    assign pixel_b = pattern_q[4:0];
`else
    assign pixel_r = pixel_valid ? framebuffer_rd_data[15:11] : 5'h00;
    assign pixel_g = pixel_valid ? framebuffer_rd_data[10:5]  : 6'h00;
    assign pixel_b = pixel_valid ? framebuffer_rd_data[4:0]   : 5'h00;
`endif

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Randomized bench for framebuffer_scanout against a frame-position reference model.
// Honours SCANOUT_TEST_PATTERN_EN (bench switches to W=8 colour-bar expectations).
module tb_framebuffer_scanout;

`ifdef SCANOUT_TEST_PATTERN_EN
    localparam int W = 8;
`else
    localparam int W = 4;
`endif
    localparam int H  = 3;
    localparam int HF = 1, HS = 2, HB = 1;
    localparam int VF = 1, VS = 1, VB = 1;
    localparam int HT = W + HF + HS + HB;
    localparam int VT = H + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int AW = $clog2(W * H);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data = '0;
    logic          pixel_valid, hsync_n, vsync_n, vblank, frame_start;
    logic [4:0]    pixel_r, pixel_b;
    logic [5:0]    pixel_g;

    logic [15:0]   mem [W*H];

    int vectors = 0;
    int miscompares = 0;
    bit m_run = 1'b0;
    int m_p = 0;

    framebuffer_scanout #(
        .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .FRAMEBUFFER_DATA_BITS(16),
        .FRAMEBUFFER_SIZE(W * H), .FRAMEBUFFER_ADDR_BITS(AW),
        .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .framebuffer_rd_addr(rd_addr), .framebuffer_rd_data(rd_data),
        .pixel_valid(pixel_valid), .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b),
        .hsync_n(hsync_n), .vsync_n(vsync_n), .vblank(vblank), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Synchronous-read framebuffer RAM
    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] barColour(input int hpos);
        int bar;
        bar = (hpos * 8) / W;
        return {bar[2] ? 5'h1F : 5'h00, bar[1] ? 6'h3F : 6'h00, bar[0] ? 5'h1F : 5'h00};
    endfunction

    task automatic fillMem();
        for (int i = 0; i < W * H; i++) mem[i] = 16'($urandom);
    endtask

    task automatic applyStimulus(input bit r, input bit e);
        int hp, vp;
        bit ev, ehs, evs, evb, efs;
        logic [15:0] epix;
        @(negedge clk);
        rst = r;
        enable = e;
        @(posedge clk);
        hp = m_p % HT;
        vp = m_p / HT;
        if (r) begin
            ev = 0; ehs = 1; evs = 1; evb = 1; efs = 0; epix = '0;
            m_run = 0;
            m_p = 0;
        end else begin
            ev  = m_run && hp < W && vp < H;
            ehs = !(m_run && hp >= W + HF && hp < W + HF + HS);
            evs = !(m_run && vp >= H + VF && vp < H + VF + VS);
            evb = !m_run || vp >= H;
            efs = m_run && m_p == 0;
`ifdef SCANOUT_TEST_PATTERN_EN
            epix = ev ? barColour(hp) : 16'h0000;
`else
            epix = ev ? mem[vp * W + hp] : 16'h0000;
`endif
            if (!m_run) begin
                m_run = e;
                m_p = 0;
            end else if (m_p == FT - 1) begin
                m_run = e;
                m_p = 0;
            end else begin
                m_p++;
            end
        end
        #1;
        checkOutput("pixel_valid", 32'(pixel_valid), 32'(ev));
        checkOutput("hsync_n", 32'(hsync_n), 32'(ehs));
        checkOutput("vsync_n", 32'(vsync_n), 32'(evs));
        checkOutput("vblank", 32'(vblank), 32'(evb));
        checkOutput("frame_start", 32'(frame_start), 32'(efs));
        checkOutput("pixel_rgb", 32'({pixel_r, pixel_g, pixel_b}), 32'(epix));
        hp = m_p % HT;
        vp = m_p / HT;
`ifdef SCANOUT_TEST_PATTERN_EN
        checkOutput("rd_addr", 32'(rd_addr), 32'd0);
`else
        if (!m_run) checkOutput("rd_addr_idle", 32'(rd_addr), 32'd0);
        else if (hp < W && vp < H) checkOutput("rd_addr", 32'(rd_addr), 32'(vp * W + hp));
`endif
    endtask

    initial begin
        fillMem();
        repeat (3) applyStimulus(1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0);
        // Back-to-back frames, then enable dropped in line 1 of the second frame
        repeat (FT + HT + 2) applyStimulus(1'b0, 1'b1);
        repeat (FT + 4) applyStimulus(1'b0, 1'b0);
        fillMem();
        // Reset at line 1, h=2, then restart from address 0
        repeat (HT + 3) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        repeat (FT + 2) applyStimulus(1'b0, 1'b1);
        repeat (600) applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
